// File: rtl/regfile_dp.sv
// ---------------------------------------------------------------------------
// regfile_dp
//   Parametrised register file: one byte-enabled write port, two independent
//   synchronous read ports, optional hardwired-zero entry 0, optional
//   write-to-read bypass, optional output register stage, and a self-clearing
//   sweep of the whole array after every reset.
//
// Ports
//   clk_i                  rising-edge clock
//   reset_i                synchronous, active-high reset
//   rd_en_{a,b}_i          read request
//   rd_addr_{a,b}_i        read address
//   rd_data_{a,b}_o        read data (latency 1, or 2 with OUT_REG=1)
//   rd_valid_{a,b}_o       one-cycle pulse per accepted read request
//   wr_en_i                write request
//   wr_addr_i              write address
//   wr_be_i                byte enables, bit i selects wr_data_i[8i+7:8i]
//   wr_data_i              write data
//   init_done_o            high once the clear sweep has finished
// ---------------------------------------------------------------------------
module regfile_dp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int OUT_REG  = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                rd_en_a_i,
    input  logic [ADDR_W-1:0]   rd_addr_a_i,
    output logic [DATA_W-1:0]   rd_data_a_o,
    output logic                rd_valid_a_o,
    input  logic                rd_en_b_i,
    input  logic [ADDR_W-1:0]   rd_addr_b_i,
    output logic [DATA_W-1:0]   rd_data_b_o,
    output logic                rd_valid_b_o,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    output logic                init_done_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {ST_CLEAR, ST_READY} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                init_done_q, init_done_d;
    logic                ready;

    // ---------------- sweep FSM ----------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign ready       = (state_q == ST_READY);
    assign init_done_o = init_done_q;

    // ---------------- storage ----------------
    // The sweep and the functional write share the single write port, so the
    // array stays a plain 1W/2R memory that tools can map to RAM.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_zero;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [NB-1:0]     mem_be;
    logic [DATA_W-1:0] mem_wdata;

    assign wr_zero   = (ZERO_REG != 0) && (wr_addr_i == '0);
    assign mem_we    = !reset_i && (!ready || (wr_en_i && !wr_zero));
    assign mem_addr  = ready ? wr_addr_i : cnt_q;
    assign mem_be    = ready ? wr_be_i   : {NB{1'b1}};
    assign mem_wdata = ready ? wr_data_i : '0;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (mem_we && mem_be[i])
                mem_q[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
    end

    // ---------------- read ports ----------------
    logic [1:0]             rd_en;
    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;
    logic [1:0]             rd_valid;

    assign rd_en   = {rd_en_b_i, rd_en_a_i};
    assign rd_addr = {rd_addr_b_i, rd_addr_a_i};

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [DATA_W-1:0] old_w, new_w, s1_d, s1_q, s2_q;
        logic              coll, rd_zero, v1_d, v1_q, v2_q;

        assign old_w   = mem_q[rd_addr[p]];
        assign coll    = wr_en_i && (rd_addr[p] == wr_addr_i);
        assign rd_zero = (ZERO_REG != 0) && (rd_addr[p] == '0);

        // Word as it will look after this cycle's write lands.
        always_comb begin
            new_w = old_w;
            for (int i = 0; i < NB; i++)
                if (wr_be_i[i]) new_w[8*i +: 8] = wr_data_i[8*i +: 8];
        end

        always_comb begin
            v1_d = ready && rd_en[p];
            s1_d = s1_q;
            if (v1_d) begin
                if (rd_zero)                   s1_d = '0;
                else if (BYPASS != 0 && coll)  s1_d = new_w;
                else                           s1_d = old_w;
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                s1_q <= '0;
                v1_q <= 1'b0;
            end else begin
                s1_q <= s1_d;
                v1_q <= v1_d;
            end
        end

        if (OUT_REG != 0) begin : g_out
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    s2_q <= '0;
                    v2_q <= 1'b0;
                end else begin
                    s2_q <= s1_q;
                    v2_q <= v1_q;
                end
            end
            assign rd_data[p]  = s2_q;
            assign rd_valid[p] = v2_q;
        end else begin : g_noout
            assign s2_q        = '0;
            assign v2_q        = 1'b0;
            assign rd_data[p]  = s1_q;
            assign rd_valid[p] = v1_q;
        end
    end

    assign rd_data_a_o  = rd_data[0];
    assign rd_data_b_o  = rd_data[1];
    assign rd_valid_a_o = rd_valid[0];
    assign rd_valid_b_o = rd_valid[1];

endmodule

// File: tb/tb_regfile_dp.sv
// Directed bench: u_dut uses the default parameters (ZERO_REG=1, BYPASS=1,
// OUT_REG=0); u_alt sees the same stimulus with ZERO_REG=0, BYPASS=0,
// OUT_REG=1 so its data arrives one edge later.
module tb_regfile_dp;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_en_a = 0, rd_en_b = 0, wr_en = 0;
    logic [4:0]  rd_addr_a = 0, rd_addr_b = 0, wr_addr = 0;
    logic [3:0]  wr_be = 0;
    logic [31:0] wr_data = 0;

    logic [31:0] d_a, d_b, x_a, x_b;
    logic        d_va, d_vb, d_done, x_va, x_vb, x_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_dp u_dut (
        .clk_i(clk), .reset_i(reset),
        .rd_en_a_i(rd_en_a), .rd_addr_a_i(rd_addr_a), .rd_data_a_o(d_a), .rd_valid_a_o(d_va),
        .rd_en_b_i(rd_en_b), .rd_addr_b_i(rd_addr_b), .rd_data_b_o(d_b), .rd_valid_b_o(d_vb),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .init_done_o(d_done)
    );

    regfile_dp #(.ZERO_REG(0), .BYPASS(0), .OUT_REG(1)) u_alt (
        .clk_i(clk), .reset_i(reset),
        .rd_en_a_i(rd_en_a), .rd_addr_a_i(rd_addr_a), .rd_data_a_o(x_a), .rd_valid_a_o(x_va),
        .rd_en_b_i(rd_en_b), .rd_addr_b_i(rd_addr_b), .rd_data_b_o(x_b), .rd_valid_b_o(x_vb),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
        .init_done_o(x_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en_a = 0; rd_en_b = 0; wr_en = 0;
        rd_addr_a = 0; rd_addr_b = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_be = be; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    // Bounded wait for init_done; returns edges counted since call.
    task automatic wait_init(output int n);
        n = 0;
        while (!d_done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        reset = 1; tick(); tick();
        n_tests++;
        if ({d_a, d_b, d_va, d_vb, d_done} !== 67'd0) begin
            n_fail++; $display("FAIL reset_dut: got %h want 0", {d_a, d_b, d_va, d_vb, d_done});
        end
        n_tests++;
        if ({x_a, x_b, x_va, x_vb, x_done} !== 67'd0) begin
            n_fail++; $display("FAIL reset_alt: got %h want 0", {x_a, x_b, x_va, x_vb, x_done});
        end
        reset = 0;
        wait_init(n);
        n_tests++;
        if (n !== 32) begin n_fail++; $display("FAIL clear_latency: got %0d want 32", n); end
        n_tests++;
        if (x_done !== 1'b1) begin n_fail++; $display("FAIL clear_alt_done: got %b want 1", x_done); end
        // restart mid-sweep
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1; tick(); reset = 0;
        n_tests++;
        if (d_done !== 1'b0) begin n_fail++; $display("FAIL midsweep_done_low: got %b want 0", d_done); end
        wait_init(n);
        n_tests++;
        if (n !== 32) begin n_fail++; $display("FAIL midsweep_latency: got %0d want 32", n); end
    endtask

    task automatic test_clear();
        int  n;
        logic saw;
        reset = 1; tick(); reset = 0;
        n = 0; saw = 0;
        while (!d_done && n < 40) begin
            if (n >= 10) begin
                rd_en_a = 1; rd_addr_a = n[4:0]; rd_en_b = 1; rd_addr_b = 5'd4;
                wr_en = 1; wr_addr = 5'd4; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
            end
            tick();
            n++;
            saw = saw | d_va | d_vb | x_va | x_vb | (|d_a) | (|d_b) | (|x_a) | (|x_b);
        end
        idle();
        n_tests++;
        if (n !== 32) begin n_fail++; $display("FAIL clear_req_latency: got %0d want 32", n); end
        n_tests++;
        if (saw !== 1'b0) begin n_fail++; $display("FAIL clear_req_ignored: got activity %b want 0", saw); end
        // every entry reads 0, including addr 4 written during the sweep
        for (int i = 0; i <= 32; i++) begin
            if (i < 32) begin
                rd_en_a = 1; rd_addr_a = 5'(i); rd_en_b = 1; rd_addr_b = 5'(31 - i);
            end else idle();
            tick();
            if (i < 32) begin
                n_tests++;
                if ({d_a, d_b, d_va, d_vb} !== {64'd0, 2'b11}) begin
                    n_fail++; $display("FAIL clear_read_dut[%0d]: got %h want 0/valid", i, {d_a, d_b, d_va, d_vb});
                end
            end
            if (i > 0) begin
                n_tests++;
                if ({x_a, x_b, x_va, x_vb} !== {64'd0, 2'b11}) begin
                    n_fail++; $display("FAIL clear_read_alt[%0d]: got %h want 0/valid", i - 1, {x_a, x_b, x_va, x_vb});
                end
            end
        end
        idle();
    endtask

    task automatic test_basic();
        do_write(5'd7, 4'hF, 32'hDEADBEEF);
        rd_en_a = 1; rd_addr_a = 5'd7; rd_en_b = 1; rd_addr_b = 5'd7;
        tick(); idle();
        n_tests++;
        if ({d_a, d_b, d_va, d_vb} !== {32'hDEADBEEF, 32'hDEADBEEF, 2'b11}) begin
            n_fail++; $display("FAIL basic_dut: got %h want deadbeef x2 valid", {d_a, d_b, d_va, d_vb});
        end
        n_tests++;
        if ({x_va, x_vb} !== 2'b00) begin n_fail++; $display("FAIL basic_alt_early: got %b want 00", {x_va, x_vb}); end
        tick();
        n_tests++;
        if ({x_a, x_b, x_va, x_vb} !== {32'hDEADBEEF, 32'hDEADBEEF, 2'b11}) begin
            n_fail++; $display("FAIL basic_alt: got %h want deadbeef x2 valid", {x_a, x_b, x_va, x_vb});
        end
        n_tests++;
        if ({d_va, d_vb} !== 2'b00) begin n_fail++; $display("FAIL basic_dut_pulse: got %b want 00", {d_va, d_vb}); end
    endtask

    task automatic test_byte_en();
        do_write(5'd3, 4'hF, 32'h11223344);
        do_write(5'd3, 4'b0101, 32'hAABBCCDD);
        do_write(5'd3, 4'b0000, 32'hFFFFFFFF);
        rd_en_a = 1; rd_addr_a = 5'd3;
        tick(); idle();
        n_tests++;
        if ({d_a, d_va} !== {32'h11BB33DD, 1'b1}) begin
            n_fail++; $display("FAIL byte_en_dut: got %h want 11bb33dd", d_a);
        end
        tick();
        n_tests++;
        if ({x_a, x_va} !== {32'h11BB33DD, 1'b1}) begin
            n_fail++; $display("FAIL byte_en_alt: got %h want 11bb33dd", x_a);
        end
    endtask

    task automatic test_zero();
        do_write(5'd0, 4'hF, 32'hFFFFFFFF);
        rd_en_a = 1; rd_addr_a = 5'd0;
        tick(); idle();
        n_tests++;
        if ({d_a, d_va} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL zero_reg_dut: got %h want 0", d_a); end
        tick();
        n_tests++;
        if ({x_a, x_va} !== {32'hFFFFFFFF, 1'b1}) begin n_fail++; $display("FAIL zero_reg_alt: got %h want ffffffff", x_a); end
    endtask

    task automatic test_collision();
        wr_en = 1; wr_addr = 5'd5; wr_be = 4'hF; wr_data = 32'h12345678;
        rd_en_a = 1; rd_addr_a = 5'd5; rd_en_b = 1; rd_addr_b = 5'd5;
        tick(); idle();
        n_tests++;
        if ({d_a, d_b, d_va, d_vb} !== {32'h12345678, 32'h12345678, 2'b11}) begin
            n_fail++; $display("FAIL coll_bypass: got %h want 12345678 x2", {d_a, d_b, d_va, d_vb});
        end
        tick();
        n_tests++;
        if ({x_a, x_b, x_va, x_vb} !== {64'h0, 2'b11}) begin
            n_fail++; $display("FAIL coll_nobypass: got %h want 0 x2", {x_a, x_b, x_va, x_vb});
        end
        rd_en_a = 1; rd_addr_a = 5'd5;
        tick(); idle(); tick();
        n_tests++;
        if (x_a !== 32'h12345678) begin n_fail++; $display("FAIL coll_after_alt: got %h want 12345678", x_a); end
        // partial-lane collision: bypass merges enabled lanes onto old word
        wr_en = 1; wr_addr = 5'd5; wr_be = 4'b0011; wr_data = 32'hAABBCCDD;
        rd_en_a = 1; rd_addr_a = 5'd5;
        tick(); idle();
        n_tests++;
        if (d_a !== 32'h1234CCDD) begin n_fail++; $display("FAIL coll_merge_dut: got %h want 1234ccdd", d_a); end
        tick();
        n_tests++;
        if (x_a !== 32'h12345678) begin n_fail++; $display("FAIL coll_merge_alt: got %h want 12345678", x_a); end
        rd_en_a = 1; rd_addr_a = 5'd5;
        tick(); idle(); tick();
        n_tests++;
        if (x_a !== 32'h1234CCDD) begin n_fail++; $display("FAIL coll_merge_after: got %h want 1234ccdd", x_a); end
    endtask

    task automatic test_hold();
        do_write(5'd9, 4'hF, 32'hCAFEF00D);
        rd_en_a = 1; rd_addr_a = 5'd9;
        tick(); idle();
        n_tests++;
        if ({d_a, d_va} !== {32'hCAFEF00D, 1'b1}) begin n_fail++; $display("FAIL hold_first: got %h want cafef00d", d_a); end
        wr_en = 1; wr_addr = 5'd9; wr_be = 4'hF; wr_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if ({d_a, d_va} !== {32'hCAFEF00D, 1'b0}) begin
                n_fail++; $display("FAIL hold_dut[%0d]: got %h/%b want cafef00d/0", i, d_a, d_va);
            end
            n_tests++;
            if ({x_a, x_va} !== {32'hCAFEF00D, (i == 0)}) begin
                n_fail++; $display("FAIL hold_alt[%0d]: got %h/%b want cafef00d/%0d", i, x_a, x_va, (i == 0));
            end
        end
        idle();
        rd_en_a = 1; rd_addr_a = 5'd9;
        tick(); idle();
        n_tests++;
        if ({d_a, d_va} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL hold_reread: got %h want 0", d_a); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_write(5'(10 + i), 4'hF, 32'h100 + i);
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) begin
                rd_en_a = 1; rd_addr_a = 5'(10 + i); rd_en_b = 1; rd_addr_b = 5'(13 - i);
            end else idle();
            tick();
            if (i < 4) begin
                n_tests++;
                if ({d_a, d_b, d_va, d_vb} !== {32'h100 + i, 32'h103 - i, 2'b11}) begin
                    n_fail++; $display("FAIL b2b_dut[%0d]: got %h", i, {d_a, d_b, d_va, d_vb});
                end
            end
            if (i > 0) begin
                n_tests++;
                if ({x_a, x_b, x_va, x_vb} !== {32'h100 + i - 1, 32'h103 - i + 1, 2'b11}) begin
                    n_fail++; $display("FAIL b2b_alt[%0d]: got %h", i - 1, {x_a, x_b, x_va, x_vb});
                end
            end
        end
        idle();
    endtask

    task automatic test_reset_ready();
        int n;
        reset = 1; tick();
        n_tests++;
        if ({d_a, d_b, d_va, d_vb, d_done} !== 67'd0) begin
            n_fail++; $display("FAIL reready_dut: got %h want 0", {d_a, d_b, d_va, d_vb, d_done});
        end
        reset = 0;
        wait_init(n);
        n_tests++;
        if (n !== 32) begin n_fail++; $display("FAIL reready_latency: got %0d want 32", n); end
        rd_en_a = 1; rd_addr_a = 5'd7; rd_en_b = 1; rd_addr_b = 5'd3;
        tick(); idle();
        n_tests++;
        if ({d_a, d_b, d_va, d_vb} !== {64'h0, 2'b11}) begin
            n_fail++; $display("FAIL reready_read_dut: got %h want 0", {d_a, d_b, d_va, d_vb});
        end
        tick();
        n_tests++;
        if ({x_a, x_b, x_va, x_vb} !== {64'h0, 2'b11}) begin
            n_fail++; $display("FAIL reready_read_alt: got %h want 0", {x_a, x_b, x_va, x_vb});
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_basic();
        test_byte_en();
        test_zero();
        test_collision();
        test_hold();
        test_back_to_back();
        test_reset_ready();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_dp.md
# regfile_dp

Parametrised register-file memory for the core's integer and CSR-shadow storage. It is the successor to the fixed 32×32 dual-port block-RAM wrapper and provides:
- one write port with byte enables and two independent synchronous read ports;
- an optional hardwired-zero entry 0 and optional write-to-read bypass;
- an optional output pipeline register;
- a self-clearing initialisation sweep after reset.

It sits between the decode/writeback stages and replaces vendor-primitive instantiation with portable, inferable RTL.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data is forwarded to a colliding read; 0 = the read returns old data
- OUT_REG, 0, 1 = extra output register stage, so read latency is 2 instead of 1

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- rd_en_a  in  1  read request, port A
- rd_addr_a  in  ADDR_W  read address, port A
- rd_data_a  out  DATA_W  read data, port A
- rd_valid_a  out  1  one-cycle pulse when rd_data_a carries a requested word
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b: same as port A, for port B
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_be  in  DATA_W/8  byte enables; bit i selects data[8i+7:8i]
- wr_data  in  DATA_W  write data
- init_done  out  1  high once the clear sweep has finished

## Operation
- **State machine: CLEAR → READY.**
  - reset=1 forces CLEAR, clear counter=0, init_done=0.
  - All rd_data=0 and all rd_valid=0, including any OUT_REG stage.
- **CLEAR.**
  - Each edge with reset=0 writes 0 to mem[counter], then increments the counter.
  - On the edge that writes entry DEPTH-1, the block moves to READY and sets init_done=1.
  - rd_en and wr_en are ignored. rd_data holds 0 and rd_valid holds 0.
- **READY.** Stays in READY until reset.
- **Reset mid-sweep** restarts the sweep from entry 0. Reset in READY re-clears the whole array.
- **Write** (READY, wr_en=1):
  - mem[wr_addr] byte lane i takes wr_data lane i where wr_be[i]=1; other lanes are unchanged.
  - wr_be=0 is a legal no-op.
  - With ZERO_REG=1, wr_addr=0 is discarded.
- **Read** (READY, rd_en_x=1): stage-1 register loads mem[rd_addr_x].
  - With ZERO_REG=1 and rd_addr_x=0, it loads 0.
  - With rd_en_x=0, stage 1 holds its value.
- **Collision** (rd_en_x & wr_en & rd_addr_x==wr_addr, address non-zero or ZERO_REG=0):
  - BYPASS=1: returns the byte-merged new word (enabled lanes from wr_data, others from mem).
  - BYPASS=0: returns the pre-write word.
- **Both ports on the same address** always return identical data.
- **OUT_REG=1:** stage 2 copies stage 1 every cycle, and rd_valid is delayed to match.
- **Storage:** no read-during-clear hazards; the array is inferable as distributed or block RAM.

## Timing
- Reset values: rd_data_a/b=0, rd_valid_a/b=0, init_done=0.
- Clear latency:
  - Reset released before edge E0.
  - Entry k is cleared at edge E0+k.
  - init_done=1 after edge E0+DEPTH-1.
  - First accepted request is sampled at edge E0+DEPTH.
- Read latency (from the sampling edge of rd_en to the output):
  - OUT_REG=0: data and valid are visible after that same edge.
  - OUT_REG=1: visible one edge later.
- rd_valid_x is high for exactly one cycle per accepted request; back-to-back requests give continuous valid.
- Write latency: a non-colliding read in the cycle after a write edge returns the new data.
- Throughput: one write plus two reads per cycle, no stalls after init_done.

## Test plan
- **Reset/clear** (ADDR_W=5): pulse reset 1 cycle.
  - init_done must rise after exactly 32 edges.
  - Reading every address must return 0.
  - Reset asserted at sweep cycle 10 must restart the sweep: still 32 edges from release.
- **Basic R/W:**
  - Write 0xDEADBEEF to addr 7 with wr_be=4'hF, then read it on A and B in the next cycle.
  - Both ports must return 0xDEADBEEF with rd_valid=1 after 1 edge, or 2 edges with OUT_REG=1.
- **Byte enables:**
  - addr 3 holds 0x11223344; write 0xAABBCCDD with wr_be=4'b0101.
  - A read must return 0x11BB33DD.
- **Zero register:** write 0xFFFFFFFF to addr 0.
  - ZERO_REG=1: read returns 0.
  - ZERO_REG=0: read returns 0xFFFFFFFF.
- **Collision:** addr 5 holds 0x0; in one cycle write 0x12345678 (wr_be=4'hF) and read addr 5 on both ports.
  - BYPASS=1: both ports return 0x12345678.
  - BYPASS=0: both ports return 0x0; a read in the next cycle returns 0x12345678.
- **Hold/valid:**
  - Read addr 9 (0xCAFEF00D), then drop rd_en for 4 cycles while writing addr 9 = 0.
  - rd_data must stay 0xCAFEF00D and rd_valid must be low for those 4 cycles.
  - Requests during CLEAR must give no valid and no memory change.
